synaptic_update_ctrl: RTL and testbench
=======================================

SYNAPTIC_UPDATE_CTRL -- requirements
Module: synaptic_update_ctrl

Interface
REQ-001 SHALL have parameter PRE_NEURONS, default 784, number of pre-synaptic neurons swept.
REQ-002 SHALL have parameter POST_WORDS, default 64, number of SRAM words per pre-neuron row (OUTPUT_NEURON / POST_NEUR_PARALLEL).
REQ-003 SHALL have parameter SYN_ARRAY_ADDR_WIDTH, default 16, synaptic SRAM address width.
REQ-004 SHALL have parameter PRE_NEUR_ADDR_WIDTH, default 10, pre-neuron address width.
REQ-005 SHALL have parameter POST_WORD_ADDR_WIDTH, default 8, post-word index width.
REQ-006 SHALL have parameter PRE_CNT_WIDTH, default 8, pre-spike count width.
REQ-007 SHALL have ports: CLK  in  1  sole clock, rising edge.
REQ-008 SHALL have RST_N  in  1  asynchronous, active-low reset.
REQ-009 SHALL have START  in  1  one-cycle pulse that launches a weight-update sweep.
REQ-010 SHALL have IS_TRAIN  in  1  training enable, sampled with START.
REQ-011 SHALL have SKIP_ZERO  in  1  skip rows whose pre-spike count is zero, sampled with START.
REQ-012 SHALL have PRE_SPIKE_CNT  in  PRE_CNT_WIDTH  pre-neuron count, valid one cycle after PRE_NEUR_RD.
REQ-013 SHALL have HOST_REQ, HOST_WE  in  1 each  host/SPI SRAM access request and write flag.
REQ-014 SHALL have HOST_ADDR  in  SYN_ARRAY_ADDR_WIDTH  host SRAM address.
REQ-015 SHALL have HOST_GNT  out  1  host access granted in the current cycle.
REQ-016 SHALL have PRE_NEUR_RD  out  1 and PRE_NEUR_ADDR  out  PRE_NEUR_ADDR_WIDTH  pre-neuron count fetch.
REQ-017 SHALL have POST_WORD_ADDR  out  POST_WORD_ADDR_WIDTH  post-count word index.
REQ-018 SHALL have SYN_CS, SYN_WE  out  1 each and SYN_ADDR  out  SYN_ARRAY_ADDR_WIDTH  synaptic SRAM control.
REQ-019 SHALL have TREF_EVENT  out  1  weight-update enable to the update logic.
REQ-020 SHALL have BUSY  out  1 and DONE  out  1  status; DONE is a one-cycle pulse.

Function
REQ-021 SHALL implement FSM states IDLE, PRE_FETCH, PRE_CHK, RD, WR, FIN.
REQ-022 IDLE: START with IS_TRAIN=1 -> PRE_FETCH, row=0, word=0; START with IS_TRAIN=0 -> FIN with no SRAM access.
REQ-023 PRE_FETCH: PRE_NEUR_RD=1, PRE_NEUR_ADDR=row; next state PRE_CHK.
REQ-024 PRE_CHK: if SKIP_ZERO latched and PRE_SPIKE_CNT==0 -> advance row (REQ-027), else -> RD with word=0.
REQ-025 RD: SYN_CS=1, SYN_WE=0, SYN_ADDR=row*POST_WORDS+word, POST_WORD_ADDR=word; next state WR.
REQ-026 WR: SYN_CS=1, SYN_WE=1, TREF_EVENT=1, same SYN_ADDR and POST_WORD_ADDR as the preceding RD; word<POST_WORDS-1 -> word+1, RD; else advance row.
REQ-027 Row advance: row<PRE_NEURONS-1 -> row+1, PRE_FETCH; else -> FIN.
REQ-028 FIN: DONE=1 for exactly one cycle, next state IDLE.
REQ-029 BUSY SHALL be 1 in every state except IDLE.
REQ-030 Sweep latency SHALL be 2 cycles per skipped row, 2+2*POST_WORDS cycles per processed row, plus 1 cycle for FIN.
REQ-031 SYN_ADDR SHALL be computed at full SYN_ARRAY_ADDR_WIDTH and truncate without wrap checks; the product must fit by parameter choice.
REQ-032 START SHALL be ignored when not in IDLE, and SHALL NOT restart a sweep in progress.
REQ-033 HOST_GNT = HOST_REQ while in IDLE and START=0; otherwise 0. START wins over a simultaneous HOST_REQ.
REQ-034 When HOST_GNT=1: SYN_CS=1, SYN_WE=HOST_WE, SYN_ADDR=HOST_ADDR, TREF_EVENT=0.
REQ-035 In IDLE with no grant, all SRAM, pre-fetch and TREF outputs SHALL be 0.
REQ-036 SRAM outputs and TREF_EVENT SHALL be Moore (state-decoded), except the host mux of REQ-033 and REQ-034.

Reset
REQ-037 RST_N=0 SHALL asynchronously force IDLE, row=0, word=0, latched flags=0 and all outputs to 0, including mid-sweep; no DONE pulse is issued for an aborted sweep.
REQ-038 After RST_N deasserts, the first START SHALL be honoured on the first rising edge.

Verification (PRE_NEURONS=3, POST_WORDS=2)
REQ-039 START, IS_TRAIN=1, SKIP_ZERO=0 -> SRAM sequence RD0, WR0, RD1, WR1, RD2, WR2, RD3, WR3, RD4, WR4, RD5, WR5; DONE at cycle 19 after START; BUSY high for 19 cycles.
REQ-040 SKIP_ZERO=1 with PRE_SPIKE_CNT: row0=5, row1=0, row2=3 -> addresses 0, 1, 4, 5 only; DONE after 15 cycles.
REQ-041 START with IS_TRAIN=0 -> no SYN_CS; DONE one cycle later.
REQ-042 HOST_REQ held during a sweep -> HOST_GNT=0 until IDLE, then HOST_GNT=1 with SYN_ADDR=HOST_ADDR; HOST_REQ and START in the same IDLE cycle -> sweep starts and HOST_GNT=0.
REQ-043 RST_N pulsed low in WR of row 1 -> outputs 0 immediately, no DONE; a new START runs the full sweep from address 0.
REQ-044 Every WR SHALL match the SYN_ADDR of the preceding RD, with TREF_EVENT=1 only in WR cycles (checked by assertion).

Source files
------------

// File: rtl/synaptic_update_ctrl.sv
// Weight-update sweep controller: walks every pre-neuron row and issues a
// read/write pair per synaptic SRAM word, with host access muxed in IDLE.
module synaptic_update_ctrl #(
    parameter int PRE_NEURONS          = 784,
    parameter int POST_WORDS           = 64,
    parameter int SYN_ARRAY_ADDR_WIDTH = 16,
    parameter int PRE_NEUR_ADDR_WIDTH  = 10,
    parameter int POST_WORD_ADDR_WIDTH = 8,
    parameter int PRE_CNT_WIDTH        = 8
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            START,
    input  logic                            IS_TRAIN,
    input  logic                            SKIP_ZERO,
    input  logic [PRE_CNT_WIDTH-1:0]        PRE_SPIKE_CNT,
    input  logic                            HOST_REQ,
    input  logic                            HOST_WE,
    input  logic [SYN_ARRAY_ADDR_WIDTH-1:0] HOST_ADDR,
    output logic                            HOST_GNT,
    output logic                            PRE_NEUR_RD,
    output logic [PRE_NEUR_ADDR_WIDTH-1:0]  PRE_NEUR_ADDR,
    output logic [POST_WORD_ADDR_WIDTH-1:0] POST_WORD_ADDR,
    output logic                            SYN_CS,
    output logic                            SYN_WE,
    output logic [SYN_ARRAY_ADDR_WIDTH-1:0] SYN_ADDR,
    output logic                            TREF_EVENT,
    output logic                            BUSY,
    output logic                            DONE
);

    localparam int AW = SYN_ARRAY_ADDR_WIDTH;
    localparam logic [PRE_NEUR_ADDR_WIDTH-1:0] ROW_LAST =
        PRE_NEUR_ADDR_WIDTH'(PRE_NEURONS - 1);
    localparam logic [POST_WORD_ADDR_WIDTH-1:0] WORD_LAST =
        POST_WORD_ADDR_WIDTH'(POST_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, PRE_FETCH, PRE_CHK, RD, WR, FIN
    } state_t;

    state_t                          state_q, state_d;
    logic [PRE_NEUR_ADDR_WIDTH-1:0]  row_q, row_d;
    logic [POST_WORD_ADDR_WIDTH-1:0] word_q, word_d;
    logic                            skip_q, skip_d;
    logic [AW-1:0]                   sweep_addr;

    // Truncating product; parameters must keep it in range.
    assign sweep_addr = AW'(row_q) * AW'(POST_WORDS) + AW'(word_q);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            row_q   <= '0;
            word_q  <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            word_q  <= word_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        word_d         = word_q;
        skip_d         = skip_q;
        HOST_GNT       = 1'b0;
        PRE_NEUR_RD    = 1'b0;
        PRE_NEUR_ADDR  = '0;
        POST_WORD_ADDR = '0;
        SYN_CS         = 1'b0;
        SYN_WE         = 1'b0;
        SYN_ADDR       = '0;
        TREF_EVENT     = 1'b0;
        BUSY           = (state_q != IDLE);
        DONE           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    skip_d  = SKIP_ZERO;
                    row_d   = '0;
                    word_d  = '0;
                    state_d = IS_TRAIN ? PRE_FETCH : FIN;
                end else if (HOST_REQ && RST_N) begin
                    HOST_GNT = 1'b1;
                    SYN_CS   = 1'b1;
                    SYN_WE   = HOST_WE;
                    SYN_ADDR = HOST_ADDR;
                end
            end
            PRE_FETCH: begin
                PRE_NEUR_RD   = 1'b1;
                PRE_NEUR_ADDR = row_q;
                state_d       = PRE_CHK;
            end
            PRE_CHK: begin
                if (skip_q && PRE_SPIKE_CNT == '0) begin
                    if (row_q < ROW_LAST) begin
                        row_d   = row_q + 1'b1;
                        state_d = PRE_FETCH;
                    end else begin
                        state_d = FIN;
                    end
                end else begin
                    word_d  = '0;
                    state_d = RD;
                end
            end
            RD: begin
                SYN_CS         = 1'b1;
                SYN_ADDR       = sweep_addr;
                POST_WORD_ADDR = word_q;
                state_d        = WR;
            end
            WR: begin
                SYN_CS         = 1'b1;
                SYN_WE         = 1'b1;
                TREF_EVENT     = 1'b1;
                SYN_ADDR       = sweep_addr;
                POST_WORD_ADDR = word_q;
                if (word_q < WORD_LAST) begin
                    word_d  = word_q + 1'b1;
                    state_d = RD;
                end else if (row_q < ROW_LAST) begin
                    row_d   = row_q + 1'b1;
                    state_d = PRE_FETCH;
                end else begin
                    state_d = FIN;
                end
            end
            FIN: begin
                DONE    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_synaptic_update_ctrl.sv
// Directed bench for synaptic_update_ctrl with PRE_NEURONS=3, POST_WORDS=2.
module tb_synaptic_update_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START, IS_TRAIN, SKIP_ZERO;
    logic [7:0]  PRE_SPIKE_CNT = '0;
    logic        HOST_REQ, HOST_WE;
    logic [15:0] HOST_ADDR;
    logic        HOST_GNT, PRE_NEUR_RD;
    logic [9:0]  PRE_NEUR_ADDR;
    logic [7:0]  POST_WORD_ADDR;
    logic        SYN_CS, SYN_WE;
    logic [15:0] SYN_ADDR;
    logic        TREF_EVENT, BUSY, DONE;

    int checks = 0;
    int errors = 0;
    int cnt_tab [3];
    logic [16:0] evq [$];
    logic [16:0] expq [$];
    logic [15:0] last_rd = '0;
    logic gnt_seen;
    logic done_seen;
    int cyc, bcnt;

    synaptic_update_ctrl #(
        .PRE_NEURONS(3), .POST_WORDS(2)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START),
        .IS_TRAIN(IS_TRAIN), .SKIP_ZERO(SKIP_ZERO),
        .PRE_SPIKE_CNT(PRE_SPIKE_CNT),
        .HOST_REQ(HOST_REQ), .HOST_WE(HOST_WE),
        .HOST_ADDR(HOST_ADDR), .HOST_GNT(HOST_GNT),
        .PRE_NEUR_RD(PRE_NEUR_RD),
        .PRE_NEUR_ADDR(PRE_NEUR_ADDR),
        .POST_WORD_ADDR(POST_WORD_ADDR),
        .SYN_CS(SYN_CS), .SYN_WE(SYN_WE),
        .SYN_ADDR(SYN_ADDR), .TREF_EVENT(TREF_EVENT),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Count memory: data appears one cycle after the fetch strobe.
    always @(posedge CLK)
        if (PRE_NEUR_RD)
            PRE_SPIKE_CNT <= 8'(cnt_tab[PRE_NEUR_ADDR]);

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic sample();
        if (SYN_CS && !HOST_GNT) begin
            evq.push_back({SYN_WE, SYN_ADDR});
            if (!SYN_WE) last_rd = SYN_ADDR;
            else chk("wr_addr_eq_rd", 32'(SYN_ADDR), 32'(last_rd));
        end
        chk("tref_only_wr", 32'(TREF_EVENT),
            32'(SYN_CS && SYN_WE && !HOST_GNT));
        if (HOST_GNT) gnt_seen = 1'b1;
        if (DONE) done_seen = 1'b1;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        sample();
    endtask

    task automatic run_sweep(input logic train, input logic skip,
                             output int c, output int b);
        evq.delete();
        START = 1'b1;
        IS_TRAIN = train;
        SKIP_ZERO = skip;
        step();
        START = 1'b0;
        c = 1;
        b = BUSY ? 1 : 0;
        while (!DONE && c < 200) begin
            step();
            c++;
            if (BUSY) b++;
        end
        chk("done_seen", 32'(DONE), 32'd1);
    endtask

    task automatic cmp_seq(input string tag);
        chk({tag, "_len"}, 32'(evq.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < evq.size(); i++)
            chk(tag, 32'(evq[i]), 32'(expq[i]));
    endtask

    task automatic exp_full();
        expq.delete();
        for (int k = 0; k < 6; k++) begin
            expq.push_back({1'b0, 16'(k)});
            expq.push_back({1'b1, 16'(k)});
        end
    endtask

    initial begin
        cnt_tab[0] = 5; cnt_tab[1] = 0; cnt_tab[2] = 3;
        RST_N = 1'b0; START = 1'b0; IS_TRAIN = 1'b0;
        SKIP_ZERO = 1'b0; HOST_REQ = 1'b1; HOST_WE = 1'b1;
        HOST_ADDR = 16'h00AA;
        #3;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_cs", 32'(SYN_CS), 32'd0);
        chk("rst_gnt", 32'(HOST_GNT), 32'd0);
        chk("rst_prerd", 32'(PRE_NEUR_RD), 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        HOST_REQ = 1'b0;

        run_sweep(1'b1, 1'b0, cyc, bcnt);
        chk("full_cycles", 32'(cyc), 32'd19);
        chk("full_busy", 32'(bcnt), 32'd19);
        exp_full();
        cmp_seq("full_seq");
        step();
        chk("idle_busy", 32'(BUSY), 32'd0);
        chk("idle_done", 32'(DONE), 32'd0);

        run_sweep(1'b1, 1'b1, cyc, bcnt);
        chk("skip_cycles", 32'(cyc), 32'd15);
        expq.delete();
        expq.push_back({1'b0, 16'd0}); expq.push_back({1'b1, 16'd0});
        expq.push_back({1'b0, 16'd1}); expq.push_back({1'b1, 16'd1});
        expq.push_back({1'b0, 16'd4}); expq.push_back({1'b1, 16'd4});
        expq.push_back({1'b0, 16'd5}); expq.push_back({1'b1, 16'd5});
        cmp_seq("skip_seq");
        step();

        run_sweep(1'b0, 1'b0, cyc, bcnt);
        chk("notrain_cycles", 32'(cyc), 32'd1);
        chk("notrain_nocs", 32'(evq.size()), 32'd0);
        step();
        chk("notrain_idle", 32'(BUSY), 32'd0);

        HOST_REQ = 1'b1; HOST_WE = 1'b1; HOST_ADDR = 16'h1234;
        #1;
        chk("host_gnt", 32'(HOST_GNT), 32'd1);
        chk("host_cs", 32'(SYN_CS), 32'd1);
        chk("host_we", 32'(SYN_WE), 32'd1);
        chk("host_addr", 32'(SYN_ADDR), 32'h1234);
        chk("host_tref", 32'(TREF_EVENT), 32'd0);
        START = 1'b1; IS_TRAIN = 1'b1;
        #1;
        chk("start_wins_gnt", 32'(HOST_GNT), 32'd0);
        gnt_seen = 1'b0;
        run_sweep(1'b1, 1'b0, cyc, bcnt);
        chk("host_sweep_nogrant", 32'(gnt_seen), 32'd0);
        chk("host_sweep_cycles", 32'(cyc), 32'd19);
        exp_full();
        cmp_seq("host_seq");
        HOST_WE = 1'b0;
        step();
        chk("host_gnt_after", 32'(HOST_GNT), 32'd1);
        chk("host_addr_after", 32'(SYN_ADDR), 32'h1234);
        chk("host_rd_we", 32'(SYN_WE), 32'd0);
        HOST_REQ = 1'b0;
        step();

        evq.delete();
        START = 1'b1; IS_TRAIN = 1'b1; SKIP_ZERO = 1'b0;
        step();
        START = 1'b0;
        cyc = 0;
        while (!(SYN_CS && SYN_WE && SYN_ADDR == 16'd2) && cyc < 50) begin
            step();
            cyc++;
        end
        chk("reach_wr_row1", 32'(SYN_ADDR), 32'd2);
        RST_N = 1'b0;
        #1;
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_cs", 32'(SYN_CS), 32'd0);
        chk("abort_we", 32'(SYN_WE), 32'd0);
        chk("abort_tref", 32'(TREF_EVENT), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        #2;
        RST_N = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("abort_no_done", 32'(done_seen), 32'd0);
        chk("abort_idle", 32'(BUSY), 32'd0);

        run_sweep(1'b1, 1'b0, cyc, bcnt);
        chk("rerun_cycles", 32'(cyc), 32'd19);
        exp_full();
        cmp_seq("rerun_seq");
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
